bp_table_ctrl: RTL and testbench

- Branch-prediction controller that drives a TableArray-style counter table: async read port (ADDR1/DOUT1), sync write port (ADDR2/DIN/WE).
- Serves per-cycle fetch predictions and applies resolved-branch updates by read-modify-write, stealing the single read port for one cycle.
- Clears the table to weakly-not-taken after reset.
- Sits between fetch/execute and the table instance.

---
 rtl/bp_table_pkg.sv | 27 ++
 rtl/bp_table_ctrl_sat.sv | 20 ++
 rtl/bp_table_ctrl.sv | 104 ++++++++++
 tb/tb_bp_table_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_table_pkg.sv
// Shared definitions for the branch-prediction table controller.
// Holds the FSM encoding, counter constants and PC index slicing position.
package bp_table_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_UPD   = 2'd2
  } state_t;

  // Constants for the default 2-bit counter; the functions cover any width.
  localparam int CBITS_DFLT = 2;
  localparam int CNT_MAX    = (1 << CBITS_DFLT) - 1;
  localparam int CNT_INIT   = (1 << (CBITS_DFLT - 1)) - 1;

  // Word-aligned PCs: the table index starts above the byte offset.
  localparam int IDX_LSB = 2;

  function automatic int cnt_max_f(input int cbits);
    return (1 << cbits) - 1;
  endfunction

  function automatic int cnt_init_f(input int cbits);
    return (1 << (cbits - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_table_ctrl_sat.sv
// Saturating up/down counter step used for the read-modify-write update.
// Purely combinational; never wraps at either end.
module sat_counter_next #(
  parameter int CBITS = 2
) (
  input  logic [CBITS-1:0] cnt,
  input  logic             taken,
  output logic [CBITS-1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (taken) begin
      if (cnt != {CBITS{1'b1}}) cnt_nxt = cnt + CBITS'(1);
    end else begin
      if (cnt != {CBITS{1'b0}}) cnt_nxt = cnt - CBITS'(1);
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Branch-prediction table controller: clears the counter table after reset,
// serves zero-latency fetch predictions and applies updates by read-modify-write.
module bp_table_ctrl
  import bp_table_pkg::*;
#(
  parameter int ABITS  = 8,
  parameter int CBITS  = 2,
  parameter int PCBITS = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [PCBITS-1:0] FETCH_PC,
  output logic              PRED_TAKEN,
  output logic              PRED_VALID,
  input  logic              UPD_VALID,
  input  logic [PCBITS-1:0] UPD_PC,
  input  logic              UPD_TAKEN,
  output logic              UPD_READY,
  output logic [ABITS-1:0]  TBL_RADDR,
  input  logic [CBITS-1:0]  TBL_RDATA,
  output logic [ABITS-1:0]  TBL_WADDR,
  output logic [CBITS-1:0]  TBL_WDATA,
  output logic              TBL_WE
);

  localparam logic [CBITS-1:0] INIT_VAL = CBITS'(cnt_init_f(CBITS));

  state_t             state, state_nxt;
  logic [ABITS-1:0]   clr_ptr;
  logic [ABITS-1:0]   upd_idx;
  logic               upd_tk;
  logic [CBITS-1:0]   sat_out;
  logic [ABITS-1:0]   fetch_idx;
  logic [ABITS-1:0]   upd_pc_idx;

  assign fetch_idx  = FETCH_PC[IDX_LSB +: ABITS];
  assign upd_pc_idx = UPD_PC[IDX_LSB +: ABITS];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{FETCH_PC[PCBITS-1:IDX_LSB+ABITS], FETCH_PC[IDX_LSB-1:0],
                            UPD_PC[PCBITS-1:IDX_LSB+ABITS], UPD_PC[IDX_LSB-1:0]};

  sat_counter_next #(.CBITS(CBITS)) u_sat (
    .cnt     (TBL_RDATA),
    .taken   (upd_tk),
    .cnt_nxt (sat_out)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      upd_idx <= '0;
      upd_tk  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Pointer wraps back to zero on the last clear write.
      if (state == ST_CLEAR) clr_ptr <= clr_ptr + ABITS'(1);
      if (state == ST_IDLE && UPD_VALID) begin
        upd_idx <= upd_pc_idx;
        upd_tk  <= UPD_TAKEN;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    TBL_RADDR  = fetch_idx;
    TBL_WADDR  = clr_ptr;
    TBL_WDATA  = INIT_VAL;
    TBL_WE     = 1'b0;
    PRED_VALID = 1'b0;
    PRED_TAKEN = 1'b0;
    UPD_READY  = 1'b0;
    case (state)
      ST_CLEAR: begin
        TBL_WE = 1'b1;
        if (&clr_ptr) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        PRED_VALID = 1'b1;
        PRED_TAKEN = TBL_RDATA[CBITS-1];
        UPD_READY  = 1'b1;
        if (UPD_VALID) state_nxt = ST_UPD;
      end
      ST_UPD: begin
        // The read port is borrowed for this cycle, so no prediction is offered.
        TBL_RADDR = upd_idx;
        TBL_WADDR = upd_idx;
        TBL_WDATA = sat_out;
        TBL_WE    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
    if (RESET) begin
      TBL_WE     = 1'b0;
      PRED_VALID = 1'b0;
      PRED_TAKEN = 1'b0;
      UPD_READY  = 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl with a 16-entry behavioural table and a counter-array
// reference model; directed scenarios followed by a randomized traffic phase.
module tb_bp_table_ctrl;

  localparam int AB   = 4;
  localparam int CB   = 2;
  localparam int PCB  = 32;
  localparam int NW   = 1 << AB;
  localparam int CMAX = (1 << CB) - 1;
  localparam int CINI = (1 << (CB - 1)) - 1;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [PCB-1:0] FETCH_PC;
  logic           PRED_TAKEN;
  logic           PRED_VALID;
  logic           UPD_VALID;
  logic [PCB-1:0] UPD_PC;
  logic           UPD_TAKEN;
  logic           UPD_READY;
  logic [AB-1:0]  TBL_RADDR;
  logic [CB-1:0]  TBL_RDATA;
  logic [AB-1:0]  TBL_WADDR;
  logic [CB-1:0]  TBL_WDATA;
  logic           TBL_WE;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl[NW];
  logic [CB-1:0] tbl[NW];

  always #5 CLK = ~CLK;

  bp_table_ctrl #(.ABITS(AB), .CBITS(CB), .PCBITS(PCB)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FETCH_PC   (FETCH_PC),
    .PRED_TAKEN (PRED_TAKEN),
    .PRED_VALID (PRED_VALID),
    .UPD_VALID  (UPD_VALID),
    .UPD_PC     (UPD_PC),
    .UPD_TAKEN  (UPD_TAKEN),
    .UPD_READY  (UPD_READY),
    .TBL_RADDR  (TBL_RADDR),
    .TBL_RDATA  (TBL_RDATA),
    .TBL_WADDR  (TBL_WADDR),
    .TBL_WDATA  (TBL_WDATA),
    .TBL_WE     (TBL_WE)
  );

  // Behavioural table: async read, write on posedge.
  assign TBL_RDATA = tbl[TBL_RADDR];
  always @(posedge CLK) if (TBL_WE) tbl[TBL_WADDR] <= TBL_WDATA;

  function automatic int idx_of(input logic [PCB-1:0] pc);
    return int'((pc / 4) % NW);
  endfunction

  function automatic int sat_ref(input int c, input bit t);
    if (t) return (c + 1 > CMAX) ? CMAX : c + 1;
    return (c - 1 < 0) ? 0 : c - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_clear(input int steps);
    for (int k = 0; k < steps; k++) begin
      #1;
      chk("clr_we", 32'(TBL_WE), 1);
      chk("clr_waddr", 32'(TBL_WADDR), k);
      chk("clr_wdata", 32'(TBL_WDATA), CINI);
      chk("clr_pv", 32'(PRED_VALID), 0);
      chk("clr_rdy", 32'(UPD_READY), 0);
      tick();
    end
    if (steps == NW) begin
      for (int i = 0; i < NW; i++) mdl[i] = CINI;
      #1;
      chk("pv_after_clear", 32'(PRED_VALID), 1);
      tick();
    end
  endtask

  task automatic fetch_chk(input logic [PCB-1:0] pc);
    FETCH_PC = pc;
    #1;
    chk("fetch_pv", 32'(PRED_VALID), 1);
    chk("fetch_we", 32'(TBL_WE), 0);
    chk("fetch_pt", 32'(PRED_TAKEN), (mdl[idx_of(pc)] > CINI) ? 1 : 0);
    tick();
  endtask

  task automatic do_update(input logic [PCB-1:0] pc, input bit tk);
    int i, e;
    UPD_VALID = 1'b1; UPD_PC = pc; UPD_TAKEN = tk;
    #1;
    chk("upd_rdy_idle", 32'(UPD_READY), 1);
    tick();
    UPD_VALID = 1'b0;
    i = idx_of(pc);
    e = sat_ref(mdl[i], tk);
    #1;
    chk("upd_we", 32'(TBL_WE), 1);
    chk("upd_waddr", 32'(TBL_WADDR), i);
    chk("upd_wdata", 32'(TBL_WDATA), e);
    chk("upd_rdy_busy", 32'(UPD_READY), 0);
    chk("upd_pv", 32'(PRED_VALID), 0);
    mdl[i] = e;
    tick();
  endtask

  initial begin
    int acc, pend_i, e;
    bit pend_t, busy;
    logic [PCB-1:0] pcs[4];

    RESET = 1'b1; FETCH_PC = '0; UPD_VALID = 1'b0; UPD_PC = '0; UPD_TAKEN = 1'b0;
    #1;
    chk("rst_we", 32'(TBL_WE), 0);
    chk("rst_pv", 32'(PRED_VALID), 0);
    chk("rst_rdy", 32'(UPD_READY), 0);
    tick();
    tick();
    RESET = 1'b0;
    run_clear(NW);
    for (int i = 0; i < NW; i++) fetch_chk(PCB'(i * 4));

    // Saturate up then down on one entry.
    for (int n = 0; n < 3; n++) do_update(32'h40, 1'b1);
    fetch_chk(32'h40);
    for (int n = 0; n < 4; n++) do_update(32'h40, 1'b0);
    fetch_chk(32'h40);

    // Aliasing: 0x40 and 0x440 share index 0.
    do_update(32'h440, 1'b1);
    do_update(32'h40, 1'b1);
    fetch_chk(32'h440);
    fetch_chk(32'h40);

    // Held UPD_VALID: only alternate cycles are accepted.
    acc = 0;
    for (int c = 0; c < 4; c++) pcs[c] = PCB'(32'h1000 + c * 4);
    for (int c = 0; c < 4; c++) begin
      UPD_VALID = 1'b1; UPD_PC = pcs[c]; UPD_TAKEN = 1'b1;
      #1;
      chk("hold_pv", 32'(PRED_VALID), (c % 2 == 0) ? 1 : 0);
      if (UPD_READY === 1'b1) acc++;
      if (c % 2 == 1) begin
        e = sat_ref(mdl[idx_of(pcs[c-1])], 1'b1);
        chk("hold_waddr", 32'(TBL_WADDR), idx_of(pcs[c-1]));
        chk("hold_wdata", 32'(TBL_WDATA), e);
        mdl[idx_of(pcs[c-1])] = e;
      end
      tick();
    end
    UPD_VALID = 1'b0;
    chk("hold_accepted", acc, 2);

    // Randomized traffic against the counter-array model.
    busy = 1'b0; pend_i = 0; pend_t = 1'b0;
    for (int n = 0; n < 400; n++) begin
      FETCH_PC  = $urandom;
      UPD_VALID = ($urandom_range(0, 2) != 0);
      UPD_PC    = {$urandom_range(0, 3) == 0 ? 28'($urandom) : 28'd0, 4'd0} |
                  PCB'($urandom_range(0, 7) * 4);
      UPD_TAKEN = ($urandom_range(0, 1) == 1);
      #1;
      if (!busy) begin
        chk("rnd_pv", 32'(PRED_VALID), 1);
        chk("rnd_rdy", 32'(UPD_READY), 1);
        chk("rnd_we_idle", 32'(TBL_WE), 0);
        chk("rnd_pt", 32'(PRED_TAKEN), (mdl[idx_of(FETCH_PC)] > CINI) ? 1 : 0);
        if (UPD_VALID) begin
          pend_i = idx_of(UPD_PC); pend_t = UPD_TAKEN; busy = 1'b1;
        end
      end else begin
        e = sat_ref(mdl[pend_i], pend_t);
        chk("rnd_pv_busy", 32'(PRED_VALID), 0);
        chk("rnd_rdy_busy", 32'(UPD_READY), 0);
        chk("rnd_we_upd", 32'(TBL_WE), 1);
        chk("rnd_waddr", 32'(TBL_WADDR), pend_i);
        chk("rnd_wdata", 32'(TBL_WDATA), e);
        mdl[pend_i] = e;
        busy = 1'b0;
      end
      tick();
    end
    if (busy) begin
      UPD_VALID = 1'b0;
      #1;
      e = sat_ref(mdl[pend_i], pend_t);
      chk("rnd_wdata_last", 32'(TBL_WDATA), e);
      mdl[pend_i] = e;
      tick();
    end
    UPD_VALID = 1'b0;

    // Reset during the UPD cycle suppresses the write and restarts the clear.
    UPD_VALID = 1'b1; UPD_PC = 32'h40; UPD_TAKEN = 1'b1;
    #1;
    chk("rstupd_rdy", 32'(UPD_READY), 1);
    tick();
    UPD_VALID = 1'b0;
    RESET = 1'b1;
    #1;
    chk("rstupd_we", 32'(TBL_WE), 0);
    chk("rstupd_pv", 32'(PRED_VALID), 0);
    chk("rstupd_rdy0", 32'(UPD_READY), 0);
    tick();
    RESET = 1'b0;
    run_clear(NW);
    fetch_chk(32'h40);

    // Reset at clear step 7 restarts from address 0.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    run_clear(7);
    RESET = 1'b1;
    #1;
    chk("rstclr_we", 32'(TBL_WE), 0);
    tick();
    RESET = 1'b0;
    run_clear(NW);
    for (int i = 0; i < NW; i++) fetch_chk(PCB'(i * 4 + 32'h400));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
